// File: rtl/target_overlay_writer.sv
// target_overlay_writer
//
// Redraws a set of square target markers into a colour-index frame buffer.
// On an update request the current target inputs are captured ("new"
// shadow).  The previously drawn boxes ("old" shadow) are then erased
// pixel by pixel, and the new boxes are drawn the same way.  Every pixel
// of every box is visited for exactly one cycle, whether it is written or
// not, so an update always takes the same number of cycles.
//
// Ports
//   clock, reset   single clock, asynchronous active-high reset
//   targetx/y      packed coordinates, target i at [i*COORD_W +: COORD_W]
//   target_valid   bit i set = target i is drawn
//   update         redraw request, sampled only in IDLE
//   busy           high during the erase and draw passes
//   done           one-cycle pulse after the draw pass
//   mem_waddr/wdata/wenable  registered frame-buffer write port
//   fsm_state      current FSM state, for observation only
//
// Handshake: update is a level sampled on the rising edge while IDLE; it
// needs no acknowledge beyond busy rising.  mem_wenable is a one-cycle
// write strobe with no back-pressure; addr/data are zero whenever it is low.
module target_overlay_writer #(
    parameter int NUM_TARGETS  = 4,
    parameter int COORD_W      = 10,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int ADDR_W       = 19,
    parameter int INDEX_W      = 3,
    parameter int MARKER_SIZE  = 4,
    parameter int MARKER_INDEX = 4,
    parameter int BG_INDEX     = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_TARGETS*COORD_W-1:0] targetx,
    input  logic [NUM_TARGETS*COORD_W-1:0] targety,
    input  logic [NUM_TARGETS-1:0]         target_valid,
    input  logic                           update,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_W-1:0]              mem_waddr,
    output logic [INDEX_W-1:0]             mem_wdata,
    output logic                           mem_wenable,
    output logic [1:0]                     fsm_state
);

    localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int DW = (MARKER_SIZE > 1) ? $clog2(MARKER_SIZE) : 1;

    // Pixel arithmetic width: a coordinate plus the box offset needs one bit
    // more than the larger of the two; the row product adds the bits of
    // SCREEN_W and one more for the column add.
    localparam int S_BITS   = $clog2(MARKER_SIZE + 1);
    localparam int PW       = ((COORD_W > S_BITS) ? COORD_W : S_BITS) + 1;
    localparam int WIDE_RAW = PW + $clog2(SCREEN_W + 1) + 1;
    localparam int WIDE     = (WIDE_RAW > ADDR_W) ? WIDE_RAW : ADDR_W;

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t state, state_next;

    logic [COORD_W-1:0]     old_x [NUM_TARGETS];
    logic [COORD_W-1:0]     old_y [NUM_TARGETS];
    logic [COORD_W-1:0]     new_x [NUM_TARGETS];
    logic [COORD_W-1:0]     new_y [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] old_valid;
    logic [NUM_TARGETS-1:0] new_valid;

    logic [TW-1:0] tgt;
    logic [DW-1:0] dy;
    logic [DW-1:0] dx;
    // Set after the last DRAW visit has been issued; DRAW then spends one
    // more cycle with the final pixel on the bus before moving to DONE.
    logic          draw_end;

    logic               last_visit;
    logic               visiting;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               cur_valid;
    logic [WIDE-1:0]    px;
    logic [WIDE-1:0]    py;
    logic [WIDE-1:0]    pix_addr;
    logic               on_screen;

    assign busy      = (state == ERASE) || (state == DRAW);
    assign done      = (state == DONE);
    assign fsm_state = state;

    assign last_visit = (tgt == TW'(NUM_TARGETS - 1)) &&
                        (dy  == DW'(MARKER_SIZE - 1)) &&
                        (dx  == DW'(MARKER_SIZE - 1));
    assign visiting   = (state == ERASE) || ((state == DRAW) && !draw_end);

    // Current pixel, taken from the old shadow while erasing and the new
    // shadow while drawing.
    always_comb begin
        cur_x     = new_x[tgt];
        cur_y     = new_y[tgt];
        cur_valid = new_valid[tgt];
        if (state == ERASE) begin
            cur_x     = old_x[tgt];
            cur_y     = old_y[tgt];
            cur_valid = old_valid[tgt];
        end
    end

    assign px        = WIDE'(cur_x) + WIDE'(dx);
    assign py        = WIDE'(cur_y) + WIDE'(dy);
    assign on_screen = (px < WIDE'(SCREEN_W)) && (py < WIDE'(SCREEN_H));
    assign pix_addr  = py * WIDE'(SCREEN_W) + px;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (update) state_next = ERASE;
            ERASE:   if (last_visit) state_next = DRAW;
            DRAW:    if (draw_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                old_x[i] <= '0;
                old_y[i] <= '0;
                new_x[i] <= '0;
                new_y[i] <= '0;
            end
            old_valid   <= '0;
            new_valid   <= '0;
            tgt         <= '0;
            dy          <= '0;
            dx          <= '0;
            draw_end    <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            mem_wenable <= 1'b0;
        end else begin
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            mem_wenable <= 1'b0;

            case (state)
                IDLE: begin
                    tgt      <= '0;
                    dy       <= '0;
                    dx       <= '0;
                    draw_end <= 1'b0;
                    if (update) begin
                        for (int i = 0; i < NUM_TARGETS; i++) begin
                            new_x[i] <= targetx[i*COORD_W +: COORD_W];
                            new_y[i] <= targety[i*COORD_W +: COORD_W];
                        end
                        new_valid <= target_valid;
                    end
                end

                ERASE, DRAW: begin
                    if (visiting) begin
                        if (cur_valid && on_screen) begin
                            mem_wenable <= 1'b1;
                            mem_waddr   <= pix_addr[ADDR_W-1:0];
                            mem_wdata   <= (state == ERASE) ? INDEX_W'(BG_INDEX)
                                                            : INDEX_W'(MARKER_INDEX);
                        end
                        // dx innermost, then dy, then target; the target
                        // index wraps to 0 so DRAW starts at target 0.
                        if (dx == DW'(MARKER_SIZE - 1)) begin
                            dx <= '0;
                            if (dy == DW'(MARKER_SIZE - 1)) begin
                                dy <= '0;
                                if (tgt == TW'(NUM_TARGETS - 1)) tgt <= '0;
                                else                              tgt <= tgt + TW'(1);
                            end else begin
                                dy <= dy + DW'(1);
                            end
                        end else begin
                            dx <= dx + DW'(1);
                        end
                        if ((state == DRAW) && last_visit) draw_end <= 1'b1;
                    end
                end

                DONE: begin
                    // What was just drawn becomes what the next update erases.
                    for (int i = 0; i < NUM_TARGETS; i++) begin
                        old_x[i] <= new_x[i];
                        old_y[i] <= new_y[i];
                    end
                    old_valid <= new_valid;
                    draw_end  <= 1'b0;
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_target_overlay_writer.sv
module tb_target_overlay_writer;

  localparam int N     = 4;
  localparam int CW    = 10;
  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int AW    = 19;
  localparam int IW    = 3;
  localparam int S     = 4;
  localparam int MI    = 4;
  localparam int BG    = 0;
  localparam int TOTAL = 2 * N * S * S;
  localparam int EW    = 32 + AW + IW;

  logic            clock = 1'b0;
  logic            reset;
  logic [N*CW-1:0] targetx;
  logic [N*CW-1:0] targety;
  logic [N-1:0]    target_valid;
  logic            update;
  logic            busy;
  logic            done;
  logic [AW-1:0]   mem_waddr;
  logic [IW-1:0]   mem_wdata;
  logic            mem_wenable;
  logic [1:0]      fsm_state;

  target_overlay_writer #(
    .NUM_TARGETS(N), .COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH),
    .ADDR_W(AW), .INDEX_W(IW), .MARKER_SIZE(S),
    .MARKER_INDEX(MI), .BG_INDEX(BG)
  ) dut (
    .clock(clock), .reset(reset),
    .targetx(targetx), .targety(targety), .target_valid(target_valid),
    .update(update), .busy(busy), .done(done),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];   // {cycle, addr, data} of every expected write
  int            done_q[$];  // expected done cycles
  logic [IW-1:0] mem [SW*SH];

  // Reference model: old/new marker sets
  int ox[N], oy[N], nx[N], ny[N];
  bit ov[N], nv[N];

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Erase every old box, then draw every new box; each box pixel takes one
  // cycle; only visible pixels of valid targets are written.
  task automatic push_model(input int e0);
    int j = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int i = 0; i < N; i++)
        for (int dy = 0; dy < S; dy++)
          for (int dx = 0; dx < S; dx++) begin
            int x = (ph == 1) ? nx[i] : ox[i];
            int y = (ph == 1) ? ny[i] : oy[i];
            bit v = (ph == 1) ? nv[i] : ov[i];
            if (v && (x + dx < SW) && (y + dy < SH))
              exp_q.push_back({32'(e0 + 1 + j), AW'((y + dy) * SW + x + dx),
                               IW'((ph == 1) ? MI : BG)});
            j++;
          end
    done_q.push_back(e0 + 1 + TOTAL);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_wenable) begin
        logic [EW-1:0] e;
        mem[int'(mem_waddr) % (SW * SH)] = mem_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("write_cycle", cyc, e[EW-1 -: 32]);
          check("write_addr", mem_waddr, e[IW +: AW]);
          check("write_data", mem_wdata, e[IW-1:0]);
        end
      end else begin
        check("idle_bus_zero", {mem_waddr, mem_wdata}, 0);
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", cyc, done_q.pop_front());
        check("busy_in_done", busy, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_targets();
    for (int i = 0; i < N; i++) begin
      targetx[i*CW +: CW] = CW'(nx[i]);
      targety[i*CW +: CW] = CW'(ny[i]);
      target_valid[i]     = nv[i];
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic start_update(output int e0);
    @(negedge clock);
    drive_targets();
    update = 1'b1;
    e0 = cyc + 1;
    push_model(e0);
    @(negedge clock);
    update = 1'b0;
    check("busy_after_update", busy, 1);
    // Inputs change while busy; the latched copy must be used.
    targetx      = {8'($urandom), $urandom};
    targety      = {8'($urandom), $urandom};
    target_valid = N'($urandom);
  endtask

  task automatic run_update(input bit extra);
    int e0;
    int prev = done_cnt;
    int guard = 0;
    start_update(e0);
    if (extra) begin
      wait_to(e0 + 9);
      update = 1'b1;
      @(negedge clock);
      update = 1'b0;
      wait_to(e0 + 127);
      update = 1'b1;
      @(negedge clock);
      update = 1'b0;
    end
    while (done_cnt == prev && guard < TOTAL + 50) begin
      @(negedge clock);
      guard++;
    end
    check("done_seen", done_cnt > prev, 1);
    repeat (3) @(negedge clock);
    if (extra) repeat (TOTAL + 20) @(negedge clock);
    check("done_pulses", done_cnt - prev, 1);
    check("busy_after_done", busy, 0);
    check("writes_outstanding", exp_q.size(), 0);
    for (int i = 0; i < N; i++) begin
      ox[i] = nx[i];
      oy[i] = ny[i];
      ov[i] = nv[i];
    end
  endtask

  task automatic check_markers();
    for (int i = 0; i < N; i++) begin
      if (nv[i]) begin
        int cnt = 0;
        int want = 0;
        for (int dy = 0; dy < S; dy++)
          for (int dx = 0; dx < S; dx++)
            if (nx[i] + dx < SW && ny[i] + dy < SH) begin
              want++;
              if (mem[(ny[i] + dy) * SW + nx[i] + dx] == IW'(MI)) cnt++;
            end
        check("marker_pixels", cnt, want);
      end
    end
  endtask

  task automatic random_targets(input bit rand_valid);
    for (int i = 0; i < N; i++) begin
      nx[i] = $urandom_range(0, 660);
      ny[i] = $urandom_range(0, 500);
      nv[i] = rand_valid ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e0;
    for (int k = 0; k < SW * SH; k++) mem[k] = '0;
    for (int i = 0; i < N; i++) begin
      ox[i] = 0; oy[i] = 0; ov[i] = 0;
    end
    reset = 1'b1;
    update = 1'b0;
    targetx = '0;
    targety = '0;
    target_valid = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wenable", mem_wenable, 0);
    check("reset_waddr", mem_waddr, 0);
    check("reset_wdata", mem_wdata, 0);
    check("reset_state", fsm_state, 0);
    reset = 1'b0;

    // Single target at (10,20)
    random_targets(1'b0);
    nx[0] = 10; ny[0] = 20; nv[0] = 1'b1;
    run_update(1'b0);
    check("mem_12810_drawn", mem[12810], MI);
    check("mem_14733_drawn", mem[14733], MI);

    // Move to (11,20): old box erased, new box drawn
    nx[0] = 11;
    run_update(1'b0);
    check("mem_12810_erased", mem[12810], 0);
    check("mem_12811_drawn", mem[12811], MI);

    // Corner clipping at (638,478)
    nx[0] = 638; ny[0] = 478;
    run_update(1'b0);
    check("mem_306558", mem[306558], MI);
    check("mem_306559", mem[306559], MI);
    check("mem_307198", mem[307198], MI);
    check("mem_307199", mem[307199], MI);

    // Update pulses while busy are ignored
    random_targets(1'b1);
    run_update(1'b1);
    check_markers();

    // Reset in the middle of an update
    random_targets(1'b1);
    nv[0] = 1'b1;
    start_update(e0);
    wait_to(e0 + 69);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_wenable", mem_wenable, 0);
    check("midreset_waddr", mem_waddr, 0);
    check("midreset_wdata", mem_wdata, 0);
    exp_q.delete();
    done_q.delete();
    for (int i = 0; i < N; i++) begin
      ox[i] = 0; oy[i] = 0; ov[i] = 0;
    end
    @(negedge clock);
    reset = 1'b0;

    // After the abort nothing is erased
    random_targets(1'b1);
    run_update(1'b0);

    // Four valid targets at distinct positions
    nx[0] = 100; ny[0] = 100; nx[1] = 200; ny[1] = 150;
    nx[2] = 300; ny[2] = 200; nx[3] = 400; ny[3] = 250;
    for (int i = 0; i < N; i++) nv[i] = 1'b1;
    run_update(1'b0);
    check_markers();

    // Random updates, overlaps and clipping allowed
    for (int r = 0; r < 6; r++) begin
      random_targets(1'b1);
      run_update(1'b0);
      check_markers();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
